token_embedder: RTL
===================

// Module: token_embedder
// PURPOSE
//  Downstream stage of the tokenising encoder. Walks the token-index RAM the encoder fills, one
//  token per address from 0 upward, terminated by token value 0. For each token it fetches
//  EMB_DIM elements from an embedding RAM and emits them as a valid/ready stream for the
//  tensor core. Both RAMs are external sram instances with 1-cycle registered read.
// PARAMETERS
//  ADDR_WIDTH   4  token RAM address width; also token-index width (vocab size 2**ADDR_WIDTH)
//  DATA_WIDTH   8  token RAM word and embedding element width
//  EMB_DIM      4  elements per embedding row; power of two, >=2
// PORTS
//  clk        in   1                  clock
//  rst_n      in   1                  reset; synchronous, active-low
//  cs         in   1                  start pulse; sampled only in IDLE
//  tok_addr   out  ADDR_WIDTH         token RAM read address
//  tok_dout   in   DATA_WIDTH         token RAM read data, valid 1 cycle after tok_addr
//  emb_addr   out  ADDR_WIDTH+log2(EMB_DIM)  embedding RAM address = {token, elem}
//  emb_dout   in   DATA_WIDTH         embedding RAM read data, 1-cycle latency
//  out_valid  out  1                  stream beat valid
//  out_ready  in   1                  downstream accepts beat
//  out_data   out  DATA_WIDTH         embedding element
//  out_last   out  1                  high on the final element of each token
//  busy       out  1                  high in every state except IDLE
//  done       out  1                  single-cycle pulse when the list is finished
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; tok_addr=0, emb_addr=0, out_valid=0, out_data=0,
//   out_last=0, busy=0, done=0; counters cleared. Reset mid-operation aborts at once; the
//   beat in flight is dropped.
//  FSM: IDLE -cs-> TOK_REQ (drive tok_addr=pos) -> TOK_WAIT -> TOK_CHK (sample tok_dout).
//   TOK_CHK: tok_dout==0 -> DONE; else latch tok=tok_dout[ADDR_WIDTH-1:0], elem=0 -> EMB_REQ.
//   EMB_REQ (drive emb_addr={tok,elem}) -> EMB_WAIT -> OUT (out_valid=1, out_data registered).
//   OUT: hold out_data/out_last stable until out_ready. On out_valid&out_ready:
//   elem<EMB_DIM-1 -> elem+1, EMB_REQ; else if pos==2**ADDR_WIDTH-1 -> DONE;
//   else pos+1 -> TOK_REQ. DONE: done=1 for exactly one cycle -> IDLE.
//  Latency: cs to first out_valid = 6 cycles; element-to-element >=3 cycles with out_ready=1.
//  out_last = (elem==EMB_DIM-1) while out_valid.
//  Empty list (address 0 holds 0): no beats, done 4 cycles after cs.
//  Full RAM, no terminator: all 2**ADDR_WIDTH tokens emitted; pos does not wrap; then DONE.
//  tok_dout upper bits above ADDR_WIDTH are ignored (truncated).
//  cs while busy: ignored, no restart. cs in the same cycle done is high: ignored, because
//   state is DONE.
//  Backpressure: out_ready may drop at any time; no beat is lost or duplicated.
// CONFIGURATION
//  Macro TOKEN_EMBEDDER_POS_EN:
//   Defined: out_data = emb_dout + pos[DATA_WIDTH-1:0], modulo 2**DATA_WIDTH, which adds a
//    positional offset. The addition is done in the EMB_WAIT->OUT register stage and adds no
//    cycles.
//   Undefined: out_data = emb_dout unmodified.
// STRUCTURE
//  embedder_pkg: typedef enum logic [2:0] embedder_state {IDLE, TOK_REQ, TOK_WAIT, TOK_CHK,
//   EMB_REQ, EMB_WAIT, OUT, DONE}; the terminator token constant TOK_NULL='0.
//  The module derives localparam EMB_AW=ADDR_WIDTH+$clog2(EMB_DIM).
//  There are no sub-modules; the srams are instantiated by the parent alongside the encoder.
// TESTING
//  Bench uses behavioural srams with 1-cycle latency. Embedding row t, element e holds 16*t+e.
//  1 Tokens [3,1,0], out_ready=1 -> beats 0x30,31,32,33(last),0x10,11,12,13(last); then done.
//  2 Token RAM[0]=0, cs -> no out_valid; done pulse 4 cycles after cs; busy low after it.
//  3 Token [2,0], out_ready low for 5 cycles on beat 1 -> out_data 0x21 is held for all 5;
//   the stream is 0x20..0x23 exactly once each.
//  4 All 16 tokens =5, no terminator -> 64 beats, 16 out_last; done; tok_addr ends at 15.
//  5 rst_n low during the 3rd beat -> next cycle state IDLE, out_valid=0; a fresh cs replays
//   from token 0.
//  6 POS_EN defined, tokens [1,1,0] -> 0x10..0x13, then 0x11..0x14; undefined -> 0x10..0x13 twice.

Source files
------------

// File: rtl/embedder_pkg.sv
// Shared types for the token embedder: FSM state encoding and terminator token.
// No logic; compile before token_embedder.sv.
// Imported with import embedder_pkg::*.
package embedder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOK_REQ,
    TOK_WAIT,
    TOK_CHK,
    EMB_REQ,
    EMB_WAIT,
    OUT,
    DONE
  } embedder_state;

  // A token RAM word of all zeros ends the list.
  localparam int TOK_NULL = 0;

endpackage

// File: rtl/token_embedder.sv
// Purpose: walk the token RAM from address 0 until a zero word, streaming EMB_DIM embedding elements per token.
// Latency: cs to first out_valid 6 cycles; >=3 cycles between elements; empty list gives done 4 cycles after cs.
// Backpressure: OUT holds out_data/out_last until out_ready; nothing lost or duplicated. Option macro TOKEN_EMBEDDER_POS_EN adds pos to each element.
module token_embedder
  import embedder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EMB_DIM    = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cs,
  output logic [ADDR_WIDTH-1:0]                   tok_addr,
  input  logic [DATA_WIDTH-1:0]                   tok_dout,
  output logic [ADDR_WIDTH+$clog2(EMB_DIM)-1:0]   emb_addr,
  input  logic [DATA_WIDTH-1:0]                   emb_dout,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    done
);

  localparam int EW     = $clog2(EMB_DIM);
  localparam int EMB_AW = ADDR_WIDTH + EW;
  localparam logic [ADDR_WIDTH-1:0] POS_MAX  = '1;
  localparam logic [EW-1:0]         ELEM_MAX = EW'(EMB_DIM - 1);

  embedder_state state, state_nxt;
  logic [ADDR_WIDTH-1:0] pos;
  logic [ADDR_WIDTH-1:0] tok;
  logic [EW-1:0]         elem;
  logic                  tok_is_null;
  logic                  elem_is_last;
  logic                  beat_taken;

  assign tok_is_null  = (tok_dout == DATA_WIDTH'(TOK_NULL));
  assign elem_is_last = (elem == ELEM_MAX);
  assign beat_taken   = (state == OUT) && out_ready;

  // Addresses come straight from the held registers so the srams see them stable through the wait cycle.
  assign tok_addr = pos;
  assign emb_addr = EMB_AW'({tok, elem});

  // State register; reset aborts any walk immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (cs) state_nxt = TOK_REQ;
      end
      TOK_REQ:  state_nxt = TOK_WAIT;
      TOK_WAIT: state_nxt = TOK_CHK;
      TOK_CHK:  state_nxt = tok_is_null ? DONE : EMB_REQ;
      EMB_REQ:  state_nxt = EMB_WAIT;
      EMB_WAIT: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!elem_is_last)    state_nxt = EMB_REQ;
          else if (pos == POS_MAX) state_nxt = DONE;
          else                  state_nxt = TOK_REQ;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Walk counters, latched token and the registered output beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos      <= '0;
      tok      <= '0;
      elem     <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs) begin
            pos  <= '0;
            elem <= '0;
          end
        end
        TOK_CHK: begin
          // Upper token bits beyond the vocabulary width are dropped.
          tok  <= tok_dout[ADDR_WIDTH-1:0];
          elem <= '0;
        end
        EMB_WAIT: begin
`ifdef TOKEN_EMBEDDER_POS_EN
          out_data <= emb_dout + DATA_WIDTH'(pos);
`else
          out_data <= emb_dout;
`endif
          out_last <= elem_is_last;
        end
        OUT: begin
          if (beat_taken) begin
            if (!elem_is_last)      elem <= elem + 1'b1;
            else if (pos != POS_MAX) pos <= pos + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
